// File: rtl/pc_seq_ctrl_if.sv
// Control bundle between the PC sequencer and the multicycle datapath.
// PC_SEQ_RETIRE_CNT_EN adds the retired-instruction counter output.
interface pc_seq_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        exc_req;
  logic        exec_done;
  logic        mem_read;
  logic        ir_write;
  logic        pc_write;
  logic [2:0]  pc_source;
  logic        alu_branch_calc;
  logic        link_write;
  logic        epc_write;
  logic        exec_req;
  logic [2:0]  state_dbg;
`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_cnt;

  modport master (
    input  opcode, funct, zero, exc_req, exec_done,
    output mem_read, ir_write, pc_write, pc_source,
    output alu_branch_calc, link_write, epc_write,
    output exec_req, state_dbg, retired_cnt
  );

  modport slave (
    output opcode, funct, zero, exc_req, exec_done,
    input  mem_read, ir_write, pc_write, pc_source,
    input  alu_branch_calc, link_write, epc_write,
    input  exec_req, state_dbg, retired_cnt
  );
`else
  modport master (
    input  opcode, funct, zero, exc_req, exec_done,
    output mem_read, ir_write, pc_write, pc_source,
    output alu_branch_calc, link_write, epc_write,
    output exec_req, state_dbg
  );

  modport slave (
    output opcode, funct, zero, exc_req, exec_done,
    input  mem_read, ir_write, pc_write, pc_source,
    input  alu_branch_calc, link_write, epc_write,
    input  exec_req, state_dbg
  );
`endif
endinterface

// File: rtl/pc_seq_ctrl.sv
// Multicycle MIPS PC sequencer: fetch, decode, jumps/branches, handoff.
// Optional PC_SEQ_RETIRE_CNT_EN: counts instructions retired to fetch.
module pc_seq_ctrl #(
  parameter int unsigned MEM_WAIT      = 2,
  parameter bit          EXC_ON_BAD_OP = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  pc_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FETCH_WAIT  = 3'd1,
    FETCH_LATCH = 3'd2,
    DECODE      = 3'd3,
    EXEC        = 3'd4,
    HANDOFF     = 3'd5,
    EXC         = 3'd6
  } state_e;

  localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic       is_j, is_jal, is_jr;
  logic       is_beq, is_bne;
  logic       is_ctl, is_alu, is_bad;

  logic       mem_read, ir_write, pc_write;
  logic [2:0] pc_source;
  logic       abc, link_write, epc_write;
  logic       exec_req;

  assign is_j   = bus.opcode == 6'h02;
  assign is_jal = bus.opcode == 6'h03;
  assign is_jr  = bus.opcode == 6'h00
               && bus.funct == 6'h08;
  assign is_beq = bus.opcode == 6'h04;
  assign is_bne = bus.opcode == 6'h05;
  assign is_ctl = is_j | is_jal | is_jr
                | is_beq | is_bne;

  // Everything the main control unit knows how to execute.
  assign is_alu = (bus.opcode == 6'h00)
               || (bus.opcode >= 6'h08
                   && bus.opcode <= 6'h0F)
               || (bus.opcode >= 6'h20
                   && bus.opcode <= 6'h2B);
  assign is_bad = ~is_ctl & ~is_alu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_read   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 3'b000;
    abc        = 1'b0;
    link_write = 1'b0;
    epc_write  = 1'b0;
    exec_req   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH_WAIT;
        cnt_d   = WAIT_LD;
      end
      FETCH_WAIT: begin
        mem_read = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = FETCH_LATCH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FETCH_LATCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        abc     = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        unique case (1'b1)
          is_j: begin
            pc_write  = 1'b1;
            pc_source = 3'b010;
          end
          is_jal: begin
            pc_write   = 1'b1;
            link_write = 1'b1;
            pc_source  = 3'b010;
          end
          is_jr: begin
            pc_write  = 1'b1;
            pc_source = 3'b011;
          end
          is_beq: begin
            pc_write  = bus.zero;
            pc_source = 3'b001;
          end
          is_bne: begin
            pc_write  = ~bus.zero;
            pc_source = 3'b001;
          end
          default: ;
        endcase
        if (bus.exc_req) begin
          state_d = EXC;
        end else if (is_ctl) begin
          state_d = FETCH_WAIT;
          cnt_d   = WAIT_LD;
        end else if (is_bad && EXC_ON_BAD_OP) begin
          state_d = EXC;
        end else begin
          state_d = HANDOFF;
        end
      end
      HANDOFF: begin
        exec_req = 1'b1;
        if (bus.exc_req) begin
          state_d = EXC;
        end else if (bus.exec_done) begin
          state_d = FETCH_WAIT;
          cnt_d   = WAIT_LD;
        end
      end
      EXC: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_source = 3'b100;
        state_d   = FETCH_WAIT;
        cnt_d     = WAIT_LD;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign bus.mem_read        = mem_read;
  assign bus.ir_write        = ir_write;
  assign bus.pc_write        = pc_write;
  assign bus.pc_source       = pc_source;
  assign bus.alu_branch_calc = abc;
  assign bus.link_write      = link_write;
  assign bus.epc_write       = epc_write;
  assign bus.exec_req        = exec_req;
  assign bus.state_dbg       = state_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [31:0] ret_q, ret_d;
  logic        retire;

  // EXC and IDLE also land in FETCH_WAIT but retire nothing.
  assign retire = (state_q == EXEC || state_q == HANDOFF)
               && state_d == FETCH_WAIT;
  assign ret_d  = retire ? ret_q + 32'd1 : ret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ret_q <= 32'd0;
    else        ret_q <= ret_d;
  end

  assign bus.retired_cnt = ret_q;
`endif

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Multicycle PC sequencer for the MIPS datapath.
- Drives the instruction-memory fetch wait, IR load and PC+4 update.
- Decodes control-flow instructions (J, JAL, JR, BEQ, BNE) and drives PCWrite and the PCSource mux select. The jump-address input of that mux comes from the 28-bit shifted {rs,rt,offset} field concatenated with PC[31:28].
- All other opcodes are handed off to the main control unit via a req/done handshake.

Parameters:
MEM_WAIT, 2, wait cycles between mem_read assertion and valid instruction data (1..15)
EXC_ON_BAD_OP, 1, 1 = unknown opcode raises an exception; 0 = unknown opcode is handed off

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low (0 = reset)
opcode  in  6  Instr[31:26] from Instr_Reg
funct  in  6  Instr[5:0] from Instr_Reg
zero  in  1  ALU zero flag, valid in EXEC
exc_req  in  1  external exception (overflow etc.), sampled in EXEC/HANDOFF
exec_done  in  1  main control finished a handed-off instruction
mem_read  out  1  instruction memory read strobe
ir_write  out  1  load Instr_Reg
pc_write  out  1  unconditional PC load
pc_source  out  3  000 ALU(PC+4), 001 ALUOut(branch target), 010 jump address, 011 reg A (rs), 100 exception vector
alu_branch_calc  out  1  tells main ALU mux to compute PC+(sext(off)<<2) in DECODE
link_write  out  1  write PC into $31 (JAL)
epc_write  out  1  load EPC
exec_req  out  1  handoff request to main control
state_dbg  out  3  current state encoding

Behaviour:
- States (encoding): IDLE=0, FETCH_WAIT=1, FETCH_LATCH=2, DECODE=3, EXEC=4, HANDOFF=5, EXC=6.
- Outputs are Moore, decoded from the state register except pc_write in EXEC. Every output not listed as active for a state is 0.
- Reset asserted (any time, asynchronous): state=IDLE, wait counter=0, all outputs 0. An in-flight instruction is discarded.
- IDLE: 1 cycle after reset release -> FETCH_WAIT; counter loaded with MEM_WAIT.
- FETCH_WAIT: mem_read=1; counter decrements each cycle; at 0 -> FETCH_LATCH. Duration is exactly MEM_WAIT cycles.
- FETCH_LATCH: mem_read=1, ir_write=1, pc_write=1, pc_source=000 -> DECODE.
- DECODE: alu_branch_calc=1 -> EXEC.
- EXEC: opcode decode:
  - 0x02 J: pc_write=1, src=010.
  - 0x03 JAL: link_write=1, pc_write=1, src=010.
  - 0x00 with funct 0x08 JR: pc_write=1, src=011.
  - 0x04 BEQ: pc_write=zero, src=001.
  - 0x05 BNE: pc_write=~zero, src=001.
  - Each of the above -> FETCH_WAIT, counter reloaded.
  - Other R-type/ALU/load/store opcodes (0x00 non-JR, 0x08-0x0F, 0x20-0x2B) -> HANDOFF.
  - Unknown opcode -> EXC if EXC_ON_BAD_OP=1, else HANDOFF.
- HANDOFF: exec_req=1, held until exec_done=1 seen on a clock edge -> FETCH_WAIT. exec_req is low in the cycle after done.
- exc_req=1 in EXEC or HANDOFF -> EXC; exc_req has priority over all other transitions.
- EXC: epc_write=1, pc_write=1, src=100, 1 cycle -> FETCH_WAIT.
- Simultaneous exec_done and exc_req in HANDOFF -> EXC.
- Total cycles:
  - Taken or not-taken branch and jumps: MEM_WAIT+3.
  - Handoff: MEM_WAIT+3+handoff cycles.
- MEM_WAIT=1 is legal: FETCH_WAIT lasts a single cycle.

Optional Feature:
PC_SEQ_RETIRE_CNT_EN
- Defined: adds output retired_cnt [31:0]; reset 0; increments by 1 on each transition into FETCH_WAIT from EXEC or HANDOFF (not from IDLE or EXC); wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- reset low mid-HANDOFF with exec_req=1 -> all outputs 0 immediately (asynchronous); after release: IDLE 1 cycle, then mem_read=1 for 2 cycles (MEM_WAIT=2).
- opcode=0x02 -> FETCH_LATCH pc_write src=000, then EXEC pc_write=1 src=010, next fetch starts; 5 cycles between fetch starts.
- opcode=0x04, zero=0 -> pc_write=0 in EXEC; zero=1 -> pc_write=1, src=001; opcode=0x05 gives the inverse.
- opcode=0x00, funct=0x20 -> exec_req=1 held 4 cycles until exec_done pulse, then FETCH_WAIT; funct=0x08 -> src=011, no exec_req.
- exc_req=1 during HANDOFF together with exec_done -> EXC: epc_write=1, pc_write=1, src=100 for 1 cycle; opcode=0x3F with EXC_ON_BAD_OP=1 -> same.
- PC_SEQ_RETIRE_CNT_EN defined, 3 instructions (J, BEQ, ADD handoff) plus 1 exception -> retired_cnt=3.
